// File: rtl/mem_bus_pkg.sv
// Shared opcodes, control levels and state encoding for the memory-access stage.
package mem_bus_pkg;

  localparam logic RstEnable = 1'b1;
  localparam logic Stop      = 1'b1;
  localparam logic NoStop    = 1'b0;

  localparam logic [7:0] EXE_NOP_OP = 8'b00000000;
  localparam logic [7:0] EXE_OR_OP  = 8'b00100101;
  localparam logic [7:0] EXE_LB_OP  = 8'b11100000;
  localparam logic [7:0] EXE_LBU_OP = 8'b11100100;
  localparam logic [7:0] EXE_LH_OP  = 8'b11100001;
  localparam logic [7:0] EXE_LHU_OP = 8'b11100101;
  localparam logic [7:0] EXE_LW_OP  = 8'b11100011;
  localparam logic [7:0] EXE_SB_OP  = 8'b11101000;
  localparam logic [7:0] EXE_SH_OP  = 8'b11101001;
  localparam logic [7:0] EXE_SW_OP  = 8'b11101011;

  typedef enum logic [1:0] {
    MemIdle = 2'd0,
    MemBusy = 2'd1,
    MemHold = 2'd2
  } mem_state_e;

  function automatic logic is_load_op(input logic [7:0] op);
    return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
  endfunction

  function automatic logic is_store_op(input logic [7:0] op);
    return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
  endfunction

endpackage

// File: rtl/mem_bus_align.sv
// Big-endian lane logic: byte enables and replicated store data for issue,
// and lane extraction with sign/zero extension for returned load data.
module mem_bus_align
  import mem_bus_pkg::*;
(
  input  logic [7:0]  aluop_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] reg2_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  sel_o,
  output logic [31:0] store_data_o,
  output logic [31:0] load_data_o
);

  logic [3:0]  byte_sel;
  logic [7:0]  byte_lane;
  logic [3:0]  half_sel;
  logic [15:0] half_lane;

  always_comb begin
    byte_sel  = 4'b1000 >> addr_lo_i;
    byte_lane = 8'h00;
    case (addr_lo_i)
      2'b00:   byte_lane = rdata_i[31:24];
      2'b01:   byte_lane = rdata_i[23:16];
      2'b10:   byte_lane = rdata_i[15:8];
      default: byte_lane = rdata_i[7:0];
    endcase
    half_sel  = addr_lo_i[1] ? 4'b0011 : 4'b1100;
    half_lane = addr_lo_i[1] ? rdata_i[15:0] : rdata_i[31:16];
  end

  always_comb begin
    sel_o        = 4'b0000;
    store_data_o = 32'h0;
    load_data_o  = 32'h0;
    case (aluop_i)
      EXE_LB_OP: begin
        sel_o       = byte_sel;
        load_data_o = {{24{byte_lane[7]}}, byte_lane};
      end
      EXE_LBU_OP: begin
        sel_o       = byte_sel;
        load_data_o = {24'h0, byte_lane};
      end
      EXE_LH_OP: begin
        sel_o       = half_sel;
        load_data_o = {{16{half_lane[15]}}, half_lane};
      end
      EXE_LHU_OP: begin
        sel_o       = half_sel;
        load_data_o = {16'h0, half_lane};
      end
      EXE_LW_OP: begin
        sel_o       = 4'b1111;
        load_data_o = rdata_i;
      end
      EXE_SB_OP: begin
        sel_o        = byte_sel;
        store_data_o = {4{reg2_i[7:0]}};
      end
      EXE_SH_OP: begin
        sel_o        = half_sel;
        store_data_o = {2{reg2_i[15:0]}};
      end
      EXE_SW_OP: begin
        sel_o        = 4'b1111;
        store_data_o = reg2_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_bus.sv
// MEM pipeline stage: issues one registered bus transaction per load/store,
// stalls the pipeline until ack, and buffers load data while MEM is held.
module mem_bus
  import mem_bus_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic        mem_whilo,
  input  logic [31:0] mem_hi,
  input  logic [31:0] mem_lo,
  input  logic [7:0]  mem_aluop,
  input  logic [31:0] mem_mem_addr,
  input  logic [31:0] mem_reg2,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic        wb_whilo,
  output logic [31:0] wb_hi,
  output logic [31:0] wb_lo,
  output logic        stallreq,
  output logic        bus_cyc,
  output logic        bus_stb,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic [1:0]  state_dbg
);

  mem_state_e  state_q, state_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] buf_q, buf_d;

  logic [3:0]  al_sel;
  logic [31:0] al_store;
  logic [31:0] al_load;
  logic        is_load;
  logic        is_mem;
  logic        unused_stall;

  assign unused_stall = ^{stall[5], stall[3:0]};

  // The EX/MEM register is frozen while this stage stalls, so one aligner
  // serves both the issue cycle and the ack cycle of the same instruction.
  mem_bus_align u_align (
    .aluop_i      (mem_aluop),
    .addr_lo_i    (mem_mem_addr[1:0]),
    .reg2_i       (mem_reg2),
    .rdata_i      (bus_rdata),
    .sel_o        (al_sel),
    .store_data_o (al_store),
    .load_data_o  (al_load)
  );

  assign is_load  = is_load_op(mem_aluop);
  assign is_mem   = is_load | is_store_op(mem_aluop);

  assign wb_wd    = mem_wd;
  assign wb_wreg  = mem_wreg;
  assign wb_whilo = mem_whilo;
  assign wb_hi    = mem_hi;
  assign wb_lo    = mem_lo;

  assign bus_cyc   = cyc_q;
  assign bus_stb   = cyc_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_sel   = sel_q;
  assign bus_wdata = wdata_q;
  assign state_dbg = state_q;

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    we_d     = we_q;
    addr_d   = addr_q;
    sel_d    = sel_q;
    wdata_d  = wdata_q;
    buf_d    = buf_q;
    stallreq = 1'b0;
    wb_wdata = mem_wdata;
    case (state_q)
      MemIdle: begin
        if (is_mem) begin
          stallreq = 1'b1;
          state_d  = MemBusy;
          cyc_d    = 1'b1;
          we_d     = ~is_load;
          addr_d   = {mem_mem_addr[31:2], 2'b00};
          sel_d    = al_sel;
          wdata_d  = al_store;
        end
      end
      MemBusy: begin
        if (bus_ack && cyc_q) begin
          cyc_d = 1'b0;
          we_d  = 1'b0;
          if (is_load) wb_wdata = al_load;
          if (stall[4] == Stop) begin
            buf_d   = al_load;
            state_d = MemHold;
          end else begin
            state_d = MemIdle;
          end
        end else begin
          stallreq = 1'b1;
        end
      end
      MemHold: begin
        if (is_load) wb_wdata = buf_q;
        if (stall[4] == NoStop) state_d = MemIdle;
      end
      default: state_d = MemIdle;
    endcase
    if (rst == RstEnable) stallreq = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q <= MemIdle;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      sel_q   <= 4'b0000;
      wdata_q <= 32'h0;
      buf_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: tb/tb_mem_bus.sv
// Directed bench for mem_bus: stimulus pushes expected bus and write-back
// records; monitors pop and compare when the DUT issues or retires.
module tb_mem_bus;
  import mem_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        mem_whilo;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_mem_addr;
  logic [31:0] mem_reg2;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        wb_whilo;
  logic [31:0] wb_hi;
  logic [31:0] wb_lo;
  logic        stallreq;
  logic        bus_cyc, bus_stb, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic [1:0]  state_dbg;

  // bus record: {check_wdata, we, sel, addr, wdata}; wb record: {wreg, wd, wdata}
  logic [69:0] exp_bus_q[$];
  logic [37:0] exp_wb_q[$];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_bus_starts = 0;
  logic        op_valid = 1'b0;
  logic        cyc_prev = 1'b0;
  int          resp_waits = 0;
  logic [31:0] resp_rdata = 32'h0;
  logic        resp_ack = 1'b0;
  logic        force_ack = 1'b0;
  int          wait_cnt = 0;

  assign bus_ack   = resp_ack | force_ack;
  assign bus_rdata = resp_rdata;

  mem_bus dut (
    .clk(clk), .rst(rst), .stall(stall),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
    .stallreq(stallreq),
    .bus_cyc(bus_cyc), .bus_stb(bus_stb), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_sel(bus_sel), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // bus slave: ack after resp_waits BUSY cycles
  always @(posedge clk) begin
    #1;
    if (bus_cyc && bus_stb) begin
      if (wait_cnt == resp_waits) resp_ack = 1'b1;
      else begin
        resp_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      resp_ack = 1'b0;
      wait_cnt = 0;
    end
  end

  // bus monitor: compare each new transaction at its first BUSY cycle
  always @(negedge clk) begin
    if (bus_cyc && !cyc_prev && rst !== 1'b1) begin
      logic [69:0] rec;
      n_bus_starts++;
      check("bus_stb", bus_stb, 1'b1);
      if (exp_bus_q.size() == 0) check("bus_q size", 0, 1);
      else begin
        rec = exp_bus_q.pop_front();
        if (rec[69]) check("bus txn", {1'b1, bus_we, bus_sel, bus_addr, bus_wdata}, rec);
        else check("bus txn", {bus_we, bus_sel, bus_addr}, rec[68:32]);
      end
    end
    cyc_prev = bus_cyc;
  end

  // write-back monitor: compare when the MEM stage hands over to WB
  always @(negedge clk) begin
    if (op_valid && rst === 1'b0 && !stallreq && !stall[4]) begin
      if (exp_wb_q.size() == 0) check("wb_q size", 0, 1);
      else check("wb out", {wb_wreg, wb_wd, wb_wdata}, exp_wb_q.pop_front());
    end
  end

  task automatic idle_inputs();
    mem_aluop    = EXE_NOP_OP;
    mem_wd       = 5'd0;
    mem_wreg     = 1'b0;
    mem_wdata    = 32'h0;
    mem_whilo    = 1'b0;
    mem_hi       = 32'h0;
    mem_lo       = 32'h0;
    mem_mem_addr = 32'h0;
    mem_reg2     = 32'h0;
    stall        = 6'b000000;
  endtask

  // driver: present one instruction at posedge+1 and run it to retirement
  task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                        input logic [31:0] wdata, input logic [4:0] wd, input logic wreg,
                        input logic [31:0] rdata, input int waits, input int hold_cycles,
                        input int exp_cycles, input logic [31:0] exp_wdata,
                        input logic exp_bus, input logic [69:0] exp_bus_rec);
    int cycles = 0;
    int holds  = 0;
    logic done = 1'b0;
    if (exp_bus) exp_bus_q.push_back(exp_bus_rec);
    exp_wb_q.push_back({wreg, wd, exp_wdata});
    resp_waits   = waits;
    resp_rdata   = rdata;
    mem_aluop    = op;
    mem_mem_addr = addr;
    mem_reg2     = reg2;
    mem_wdata    = wdata;
    mem_wd       = wd;
    mem_wreg     = wreg;
    stall        = (hold_cycles > 0) ? 6'b010000 : 6'b000000;
    op_valid     = 1'b1;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      cycles++;
      if (state_dbg == MemHold) begin
        holds++;
        check("hold wb_wdata", wb_wdata, exp_wdata);
        check("hold no bus", {bus_cyc, stallreq}, 2'b00);
      end
      if (!stallreq && !stall[4]) done = 1'b1;
      else begin
        @(posedge clk);
        #1;
        if (hold_cycles > 0 && holds >= hold_cycles) stall = 6'b000000;
      end
    end
    check("retired", done, 1'b1);
    check("mem cycles", cycles, exp_cycles);
    if (hold_cycles > 0) check("hold cycles", holds, hold_cycles + 1);
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    idle_inputs();
    @(negedge clk);
    check("back to idle", {state_dbg, bus_cyc}, {MemIdle, 1'b0});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    mem_aluop    = EXE_LB_OP;
    mem_mem_addr = 32'h103;
    @(negedge clk);
    check("reset stallreq", stallreq, 1'b0);
    check("reset bus ctl", {bus_cyc, bus_stb, bus_we, bus_sel}, 7'b0);
    check("reset bus addr", bus_addr, 32'h0);
    check("reset bus wdata", bus_wdata, 32'h0);
    check("reset state", state_dbg, MemIdle);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_inputs();

    // non-memory op passes through, with HI/LO controls
    mem_whilo = 1'b1;
    mem_hi    = 32'hAAAA0001;
    mem_lo    = 32'h5555FFFE;
    mem_aluop = EXE_OR_OP;
    @(negedge clk);
    check("whilo pass", {wb_whilo, wb_hi, wb_lo}, {1'b1, 32'hAAAA0001, 32'h5555FFFE});
    @(posedge clk);
    #1;
    run_op(EXE_OR_OP, 32'h0, 32'h0, 32'h1234, 5'd3, 1'b1, 32'h0, 0, 0, 1, 32'h1234,
           1'b0, 70'h0);

    // loads: op, addr, reg2, wdata, wd, wreg, rdata, waits, holds, cycles, exp, bus rec
    run_op(EXE_LB_OP, 32'h103, 32'h0, 32'h0, 5'd7, 1'b1, 32'h11223380, 0, 0, 2, 32'hFFFFFF80,
           1'b1, {1'b0, 1'b0, 4'b0001, 32'h100, 32'h0});
    run_op(EXE_LHU_OP, 32'h202, 32'h0, 32'h0, 5'd8, 1'b1, 32'h0000ABCD, 3, 0, 5, 32'h0000ABCD,
           1'b1, {1'b0, 1'b0, 4'b0011, 32'h200, 32'h0});
    run_op(EXE_LH_OP, 32'h201, 32'h0, 32'h0, 5'd9, 1'b1, 32'h80011234, 1, 0, 3, 32'hFFFF8001,
           1'b1, {1'b0, 1'b0, 4'b1100, 32'h200, 32'h0});
    run_op(EXE_LBU_OP, 32'h100, 32'h0, 32'h0, 5'd10, 1'b1, 32'h80223344, 0, 0, 2, 32'h00000080,
           1'b1, {1'b0, 1'b0, 4'b1000, 32'h100, 32'h0});

    // stores: write data passes through to write-back unchanged
    run_op(EXE_SH_OP, 32'h300, 32'hDEADBEEF, 32'h55, 5'd0, 1'b0, 32'h0, 0, 0, 2, 32'h55,
           1'b1, {1'b1, 1'b1, 4'b1100, 32'h300, 32'hBEEFBEEF});
    run_op(EXE_SB_OP, 32'h2, 32'h000000A5, 32'h66, 5'd0, 1'b0, 32'h0, 2, 0, 4, 32'h66,
           1'b1, {1'b1, 1'b1, 4'b0010, 32'h0, 32'hA5A5A5A5});
    run_op(EXE_SW_OP, 32'h7, 32'h12345678, 32'h77, 5'd0, 1'b0, 32'h0, 0, 0, 2, 32'h77,
           1'b1, {1'b1, 1'b1, 4'b1111, 32'h4, 32'h12345678});

    // ack while another stage stalls: buffered data through HOLD
    run_op(EXE_LW_OP, 32'h404, 32'h0, 32'h0, 5'd11, 1'b1, 32'hCAFEF00D, 0, 2, 5, 32'hCAFEF00D,
           1'b1, {1'b0, 1'b0, 4'b1111, 32'h404, 32'h0});
    check("no reissue in hold", n_bus_starts, 8);

    // reset while BUSY abandons the transaction
    exp_bus_q.push_back({1'b0, 1'b0, 4'b1111, 32'h500, 32'h0});
    resp_waits   = 100;
    mem_aluop    = EXE_LW_OP;
    mem_mem_addr = 32'h500;
    @(negedge clk);
    check("issue stallreq", stallreq, 1'b1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("busy before reset", {state_dbg, bus_cyc, stallreq}, {MemBusy, 1'b1, 1'b1});
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    check("stallreq in reset", stallreq, 1'b0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    force_ack = 1'b1;
    @(negedge clk);
    check("after reset", {state_dbg, bus_cyc, stallreq}, {MemIdle, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    force_ack  = 1'b0;
    resp_waits = 0;
    @(negedge clk);
    check("late ack ignored", {state_dbg, bus_cyc, stallreq}, {MemIdle, 1'b0, 1'b0});

    repeat (3) @(posedge clk);
    check("bus starts", n_bus_starts, 9);
    check("bus_q drained", exp_bus_q.size(), 0);
    check("wb_q drained", exp_wb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
